imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Instruction-memory responder on the CPU fetch interface: takes the CPU's 8-bit read_address and returns the 8-bit instruction.
- Owns a small program RAM filled over a byte-serial valid/ready load port before execution starts.
- Sits between the board-level program source (switches, UART byte stream, bench) and the cpu's instruction input.
- Gates execution through a run flag.

Parameters:
- DEPTH, 32, number of program words (1..256); addresses 0..DEPTH-1 are backed by storage.
- OOR_WORD, 8'h00, instruction returned for unloaded or out-of-range addresses and while loading.

Ports:
- clock  in  1  system clock, same clock as the CPU's clock.
- clear  in  1  synchronous active-high reset.
- load_valid  in  1  load_data holds a program byte.
- load_data  in  8  program byte.
- load_ready  out  1  block accepts a byte this cycle.
- load_done  in  1  one-cycle strobe: program complete.
- reload  in  1  one-cycle strobe: return to load mode.
- read_address  in  8  CPU fetch address (PC).
- instruction  out  8  fetched instruction.
- run  out  1  high when the program is loaded and the CPU may execute.
- oor  out  1  high in RUN when read_address >= prog_len.
- prog_len  out  9  number of loaded words (0..DEPTH).

Behaviour:
- State machine with two states, LOAD and RUN; a 9-bit wr_ptr; prog_len register; RAM mem[0..DEPTH-1].
- Reset (clear=1 at a clock edge, any state, including mid-load):
  - state=LOAD, wr_ptr=0, prog_len=0.
  - run=0, load_ready=1, oor=0, instruction=OOR_WORD.
  - RAM contents are not cleared.
  - clear has priority over every other input.
- LOAD state:
  - load_ready = (wr_ptr < DEPTH), combinational from state and wr_ptr.
  - Transfer occurs when load_valid && load_ready at the clock edge: mem[wr_ptr] <= load_data, wr_ptr <= wr_ptr+1.
  - load_valid with load_ready=0 is ignored; the byte is dropped and no error is raised.
  - load_done: next state RUN, prog_len <= wr_ptr, counting a byte transferred in the same cycle (that byte is written and included).
  - Full auto-exit: accepting the byte at wr_ptr=DEPTH-1 moves to RUN with prog_len=DEPTH on the same edge, without load_done.
  - load_done with wr_ptr=0 and no transfer: RUN with prog_len=0; every fetch returns OOR_WORD with oor=1.
  - reload is ignored in LOAD.
  - Outputs: instruction=OOR_WORD, run=0, oor=0.
- RUN state:
  - Fetch is combinational, with zero-cycle latency, because the CPU is single-cycle:
    - instruction = mem[read_address] when read_address < prog_len;
    - otherwise instruction = OOR_WORD and oor=1.
  - The comparison is unsigned and 9-bit (read_address zero-extended), so read_address 8'hFF with prog_len=256 is in range.
  - The PC wrapping past 8'hFF back to 0 needs no special handling; the address is decoded fresh every cycle.
  - load_ready=0; load_valid, load_data and load_done are ignored.
  - run=1.
- reload in RUN:
  - Next state LOAD; wr_ptr <= 0; prog_len <= 0; run falls on that edge.
  - The old RAM contents remain but are unreachable until a new load completes.
  - reload and load_valid in the same cycle: the byte is not written.
- prog_len is stable throughout RUN.
- Only prog_len, wr_ptr and state are registered.
- The RAM is write-synchronous and read-asynchronous (distributed RAM).

Test Plan:
- Load and fetch: reset, send bytes 8'h41, 8'h82, 8'hC3 with load_valid held, then pulse load_done. Expect run=1 and prog_len=3 the next cycle; read_address 0/1/2 returns 41/82/C3; read_address 3 returns 00 with oor=1.
- Simultaneous last byte and done: send 8'h11, then 8'h22 together with load_done. Expect prog_len=2 and read_address 1 returns 22.
- Full auto-exit (DEPTH=4): send 8'hA0..A3 back-to-back. Expect load_ready=0 and run=1 right after the 4th byte with prog_len=4; a 5th load_valid byte is ignored and mem[0] is still A0.
- Empty program: pulse load_done immediately after reset. Expect run=1, prog_len=0, instruction=00 and oor=1 for read_address 0 and 8'hFF.
- Reload and reset mid-operation:
  - In RUN, pulse reload. Expect run=0, load_ready=1, prog_len=0; load 8'h55, done; read_address 0 returns 55.
  - Assert clear after two bytes of a load. Expect wr_ptr restarts at 0; next byte lands at address 0.
- Handshake stall: toggle load_valid randomly over 10 bytes. Expect only the cycles with valid=1 to be written, in order, with prog_len=10.

Source files
------------

// File: rtl/imem_loader.sv
// Instruction-memory responder: program bytes stream in over a valid/ready port,
// then the CPU fetches combinationally from the loaded region while run is high.
module imem_loader #(
  parameter int          DEPTH    = 32,
  parameter logic [7:0]  OOR_WORD = 8'h00
) (
  input  logic       clock,
  input  logic       clear,
  input  logic       load_valid,
  input  logic [7:0] load_data,
  output logic       load_ready,
  input  logic       load_done,
  input  logic       reload,
  input  logic [7:0] read_address,
  output logic [7:0] instruction,
  output logic       run,
  output logic       oor,
  output logic [8:0] prog_len
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [8:0] DEPTH_W = 9'(DEPTH);
  localparam logic [8:0] LAST_W  = 9'(DEPTH - 1);

  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t     state;
  logic [8:0] wr_ptr;
  logic [7:0] mem [DEPTH];

  logic transfer;
  logic in_range;

  always_comb begin
    load_ready = (state == LOAD) && (wr_ptr < DEPTH_W);
    transfer   = load_valid && load_ready && !clear;
    run        = (state == RUN);
    // Zero-extended 9-bit compare so address 8'hFF is reachable when prog_len=256.
    in_range   = ({1'b0, read_address} < prog_len);
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    instruction = OOR_WORD;
    oor         = 1'b0;
    if (state == RUN) begin
      if (in_range) begin
        instruction = mem[read_address[AW-1:0]];
      end else begin
        oor = 1'b1;
      end
    end
  end

  // NOTE: the RAM has no reset; clearing it would turn distributed RAM into flops.
  always_ff @(posedge clock) begin
    if (transfer) begin
      mem[wr_ptr[AW-1:0]] <= load_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clock) begin
    if (clear) begin
      state    <= LOAD;
      wr_ptr   <= 9'd0;
      prog_len <= 9'd0;
    end else begin
      case (state)
        LOAD: begin
          if (transfer) begin
            wr_ptr <= wr_ptr + 9'd1;
          end
          if (load_done) begin
            // A byte accepted alongside load_done belongs to the program.
            state    <= RUN;
            prog_len <= transfer ? wr_ptr + 9'd1 : wr_ptr;
          end else if (transfer && (wr_ptr == LAST_W)) begin
            state    <= RUN;
            prog_len <= DEPTH_W;
          end
        end
        RUN: begin
          if (reload) begin
            state    <= LOAD;
            wr_ptr   <= 9'd0;
            prog_len <= 9'd0;
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a 32-word instance for the main flows and a
// 4-word instance for the full auto-exit case.
module tb_imem_loader;

  logic       clock = 1'b0;
  logic       clear;

  logic       load_valid, load_done, reload, load_ready, run, oor;
  logic [7:0] load_data, read_address, instruction;
  logic [8:0] prog_len;

  logic       s_load_valid, s_load_done, s_reload, s_load_ready, s_run, s_oor;
  logic [7:0] s_load_data, s_read_address, s_instruction;
  logic [8:0] s_prog_len;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  imem_loader #(.DEPTH(32), .OOR_WORD(8'h00)) u_dut (
    .clock(clock), .clear(clear),
    .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
    .load_done(load_done), .reload(reload),
    .read_address(read_address), .instruction(instruction),
    .run(run), .oor(oor), .prog_len(prog_len)
  );

  imem_loader #(.DEPTH(4), .OOR_WORD(8'h00)) u_small (
    .clock(clock), .clear(clear),
    .load_valid(s_load_valid), .load_data(s_load_data), .load_ready(s_load_ready),
    .load_done(s_load_done), .reload(s_reload),
    .read_address(s_read_address), .instruction(s_instruction),
    .run(s_run), .oor(s_oor), .prog_len(s_prog_len)
  );

  task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic fetch(input string tag, input logic [7:0] addr,
                       input logic [7:0] exp_instr, input logic exp_oor);
    read_address = addr;
    #1;
    check({tag, "_instr"}, 16'(instruction), 16'(exp_instr));
    check({tag, "_oor"}, 16'(oor), 16'(exp_oor));
  endtask

  task automatic send(input logic [7:0] data);
    load_valid = 1'b1;
    load_data  = data;
    tick();
    load_valid = 1'b0;
  endtask

  task automatic pulse_done();
    load_done = 1'b1;
    tick();
    load_done = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  logic [19:0] vpat;
  int          sent;

  initial begin
    clear = 1'b1;
    load_valid = 1'b0; load_data = 8'h00; load_done = 1'b0; reload = 1'b0; read_address = 8'h00;
    s_load_valid = 1'b0; s_load_data = 8'h00; s_load_done = 1'b0; s_reload = 1'b0; s_read_address = 8'h00;
    tick();
    tick();
    clear = 1'b0;

    // Reset state
    check("rst_run", 16'(run), 16'd0);
    check("rst_ready", 16'(load_ready), 16'd1);
    check("rst_oor", 16'(oor), 16'd0);
    check("rst_instr", 16'(instruction), 16'h00);
    check("rst_len", 16'(prog_len), 16'd0);

    // Full auto-exit on the 4-word instance
    for (int i = 0; i < 4; i++) begin
      s_load_valid = 1'b1;
      s_load_data  = 8'hA0 + 8'(i);
      check("full_pre_ready", 16'(s_load_ready), 16'd1);
      check("full_pre_run", 16'(s_run), 16'd0);
      tick();
    end
    check("full_ready", 16'(s_load_ready), 16'd0);
    check("full_run", 16'(s_run), 16'd1);
    check("full_len", 16'(s_prog_len), 16'd4);
    s_load_data = 8'hFF;
    tick();
    s_load_valid = 1'b0;
    s_read_address = 8'd0;
    #1;
    check("full_mem0", 16'(s_instruction), 16'hA0);
    s_read_address = 8'd3;
    #1;
    check("full_mem3", 16'(s_instruction), 16'hA3);
    check("full_len_after", 16'(s_prog_len), 16'd4);

    // Load three bytes and fetch them
    load_valid = 1'b1;
    load_data = 8'h41; tick();
    load_data = 8'h82; tick();
    load_data = 8'hC3; tick();
    load_valid = 1'b0;
    check("load_run_before_done", 16'(run), 16'd0);
    fetch("load_instr_in_load", 8'd0, 8'h00, 1'b0);
    pulse_done();
    check("load_run", 16'(run), 16'd1);
    check("load_len", 16'(prog_len), 16'd3);
    check("load_ready_run", 16'(load_ready), 16'd0);
    fetch("fetch0", 8'd0, 8'h41, 1'b0);
    fetch("fetch1", 8'd1, 8'h82, 1'b0);
    fetch("fetch2", 8'd2, 8'hC3, 1'b0);
    fetch("fetch3", 8'd3, 8'h00, 1'b1);

    // load_valid/load_done ignored in RUN
    load_valid = 1'b1; load_data = 8'h99; load_done = 1'b1;
    tick();
    load_valid = 1'b0; load_done = 1'b0;
    check("run_ignore_len", 16'(prog_len), 16'd3);
    fetch("run_ignore_fetch0", 8'd0, 8'h41, 1'b0);

    // Reload then load a single byte
    reload = 1'b1; tick(); reload = 1'b0;
    check("reload_run", 16'(run), 16'd0);
    check("reload_ready", 16'(load_ready), 16'd1);
    check("reload_len", 16'(prog_len), 16'd0);
    reload = 1'b1; tick(); reload = 1'b0;
    check("reload_in_load_run", 16'(run), 16'd0);
    send(8'h55);
    pulse_done();
    check("reload_len1", 16'(prog_len), 16'd1);
    fetch("reload_fetch0", 8'd0, 8'h55, 1'b0);

    // Reload together with load_valid: the byte is not taken
    reload = 1'b1; load_valid = 1'b1; load_data = 8'hEE;
    tick();
    reload = 1'b0; load_valid = 1'b0;
    pulse_done();
    check("reload_valid_len", 16'(prog_len), 16'd0);
    fetch("reload_valid_fetch0", 8'd0, 8'h00, 1'b1);

    // Last byte together with load_done
    reload = 1'b1; tick(); reload = 1'b0;
    send(8'h11);
    load_valid = 1'b1; load_data = 8'h22; load_done = 1'b1;
    tick();
    load_valid = 1'b0; load_done = 1'b0;
    check("simul_run", 16'(run), 16'd1);
    check("simul_len", 16'(prog_len), 16'd2);
    fetch("simul_fetch0", 8'd0, 8'h11, 1'b0);
    fetch("simul_fetch1", 8'd1, 8'h22, 1'b0);

    // Empty program
    do_clear();
    check("clear_from_run", 16'(run), 16'd0);
    pulse_done();
    check("empty_run", 16'(run), 16'd1);
    check("empty_len", 16'(prog_len), 16'd0);
    fetch("empty_fetch0", 8'd0, 8'h00, 1'b1);
    fetch("empty_fetchFF", 8'hFF, 8'h00, 1'b1);

    // Clear mid-load, with a byte offered in the clear cycle
    do_clear();
    send(8'h77);
    send(8'h78);
    clear = 1'b1; load_valid = 1'b1; load_data = 8'hAA;
    tick();
    clear = 1'b0; load_valid = 1'b0;
    check("midclear_len", 16'(prog_len), 16'd0);
    check("midclear_ready", 16'(load_ready), 16'd1);
    send(8'h99);
    pulse_done();
    check("midclear_len1", 16'(prog_len), 16'd1);
    fetch("midclear_fetch0", 8'd0, 8'h99, 1'b0);
    fetch("midclear_fetch1", 8'd1, 8'h00, 1'b1);

    // Handshake stall: valid follows a fixed irregular pattern
    do_clear();
    vpat = 20'b1101_0011_1010_1110_0111;
    sent = 0;
    for (int c = 0; c < 20 && sent < 10; c++) begin
      load_valid = vpat[c];
      load_data  = vpat[c] ? 8'h30 + 8'(sent) : 8'hEE;
      tick();
      if (vpat[c]) sent++;
    end
    load_valid = 1'b0;
    pulse_done();
    check("stall_len", 16'(prog_len), 16'd10);
    for (int i = 0; i < 10; i++) begin
      fetch($sformatf("stall_fetch%0d", i), 8'(i), 8'h30 + 8'(i), 1'b0);
    end
    fetch("stall_fetch10", 8'd10, 8'h00, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
